// File: rtl/vending_machine_param.sv
// vending_machine_param: parametrised vending controller with per-item stock, saturating credit and serial refund
module vending_machine_param #(
  parameter int N_ITEMS = 2,
  parameter int CREDIT_W = 4,
  parameter int MAX_CREDIT = 15,
  parameter int COIN_VALUE = 1,
  parameter int PRICE_W = 4,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES = {4'd2, 4'd1},
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 3,
  parameter int AUTO_CHANGE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                C,
  input  logic [N_ITEMS-1:0]  P,
  input  logic                F,
  input  logic                refill,
  output logic [N_ITEMS-1:0]  led,
  output logic [N_ITEMS-1:0]  o,
  output logic                change,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state,
  output logic [7:0]          seg
);
  typedef enum logic [1:0] {IDLE = 2'b00, VEND = 2'b01, REFUND = 2'b10} state_t;
  localparam int CW = CREDIT_W > PRICE_W ? CREDIT_W : PRICE_W;
  localparam logic [CREDIT_W:0] CV = (CREDIT_W+1)'(COIN_VALUE);
  localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0] SINIT = STOCK_W'(STOCK_INIT);
  localparam logic [15:0][7:0] SEG = {8'hF1, 8'hF9, 8'hDE, 8'hB9, 8'hFC, 8'hF7, 8'h6F, 8'h7F,
                                      8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [N_ITEMS-1:0]  o_q, avail, qual, pick;
  logic                change_q, rej_q, idle, coin_ok;
  logic [CW-1:0]       price [N_ITEMS];
  logic [CW-1:0]       price_sel, cr_x;
  logic [CREDIT_W:0]   cr1, sum;
  assign cr_x = CW'(credit_q);
  assign cr1 = {1'b0, credit_q};
  assign sum = cr1 + CV;
  assign idle = state_q == IDLE;
  // a coin is only taken when nothing of higher priority claims the cycle and it fits
  assign coin_ok = idle && !F && P == '0 && !refill && sum <= MAXC;
  for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
    assign price[i] = CW'(PRICES[i*PRICE_W +: PRICE_W]);
    assign avail[i] = cr_x >= price[i] && stock_q[i] != '0;
  end
  assign qual = P & avail;
  assign pick = qual & (~qual + N_ITEMS'(1));
  always_comb begin
    price_sel = '0;
    for (int i = 0; i < N_ITEMS; i++) price_sel = price_sel | (pick[i] ? price[i] : '0);
  end
  assign led = idle ? avail : '0;
  assign o = o_q;
  assign change = change_q;
  assign coin_reject = rej_q;
  assign busy = !idle;
  assign credit = credit_q;
  assign state = state_q;
  assign seg = SEG[4'(credit_q)];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      credit_q <= '0;
      o_q <= '0;
      change_q <= 1'b0;
      rej_q <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= SINIT;
    end else begin
      o_q <= '0;
      change_q <= 1'b0;
      rej_q <= C && !coin_ok;
      case (state_q)
        IDLE: begin
          if (F) state_q <= credit_q != '0 ? REFUND : IDLE;
          else if (P != '0) begin
            if (pick != '0) begin
              state_q <= VEND;
              o_q <= pick;
              credit_q <= CREDIT_W'(cr_x - price_sel);
            end
            for (int i = 0; i < N_ITEMS; i++) if (pick[i]) stock_q[i] <= stock_q[i] - STOCK_W'(1);
          end else if (refill) begin
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= SINIT;
          end else if (C && coin_ok) credit_q <= CREDIT_W'(sum);
        end
        VEND: state_q <= AUTO_CHANGE != 0 && credit_q != '0 ? REFUND : IDLE;
        REFUND: begin
          change_q <= 1'b1;
          credit_q <= cr1 > CV ? CREDIT_W'(cr1 - CV) : '0;
          if (cr1 <= CV) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: directed checks of the default machine and an auto-change variant
module tb_vending_machine_param;
  logic clk = 0, reset = 1, C = 0, F = 0, refill = 0;
  logic [1:0] P = '0;
  logic [1:0] led, o, led_a, o_a, state, state_a;
  logic change, coin_reject, busy, change_a, coin_reject_a, busy_a;
  logic [3:0] credit, credit_a;
  logic [7:0] seg, seg_a;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  vending_machine_param dut (
    .clk(clk), .reset(reset), .C(C), .P(P), .F(F), .refill(refill), .led(led), .o(o),
    .change(change), .coin_reject(coin_reject), .busy(busy), .credit(credit), .state(state), .seg(seg)
  );
  vending_machine_param #(.AUTO_CHANGE(1)) dut_a (
    .clk(clk), .reset(reset), .C(C), .P(P), .F(F), .refill(refill), .led(led_a), .o(o_a),
    .change(change_a), .coin_reject(coin_reject_a), .busy(busy_a), .credit(credit_a), .state(state_a), .seg(seg_a)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask
  task automatic coin();
    C = 1;
    step();
    C = 0;
  endtask
  task automatic sel(input logic [1:0] p);
    P = p;
    step();
    P = '0;
  endtask
  initial begin
    step();
    do_reset();
    chk("rst_credit", credit, 0);
    chk("rst_seg", seg, 8'h3F);
    chk("rst_led", led, 0);
    chk("rst_state", state, 0);
    chk("rst_o", o, 0);
    chk("rst_busy", busy, 0);
    coin();
    chk("t1_credit1", credit, 1);
    chk("t1_seg1", seg, 8'h06);
    coin();
    chk("t1_credit2", credit, 2);
    chk("t1_seg2", seg, 8'h5B);
    chk("t1_led", led, 2'b11);
    sel(2'b10);
    chk("t1_o", o, 2'b10);
    chk("t1_credit0", credit, 0);
    chk("t1_state_vend", state, 2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_led_vend", led, 0);
    step();
    chk("t1_o_clear", o, 0);
    chk("t1_state_idle", state, 0);
    coin();
    sel(2'b10);
    chk("t2_o_none", o, 0);
    chk("t2_credit_kept", credit, 1);
    sel(2'b01);
    chk("t2_o0", o, 2'b01);
    chk("t2_credit0", credit, 0);
    chk("t2_stock0", dut.stock_q[0], 2);
    step();
    repeat (3) coin();
    chk("t3_credit3", credit, 3);
    F = 1;
    step();
    F = 0;
    chk("t3_state_ref", state, 2'b10);
    chk("t3_chg0", change, 0);
    for (int k = 2; k >= 0; k--) begin
      step();
      chk("t3_chg", change, 1);
      chk("t3_credit", credit, k);
    end
    chk("t3_state_idle", state, 0);
    step();
    chk("t3_chg_end", change, 0);
    repeat (15) coin();
    chk("t4_credit15", credit, 15);
    chk("t4_seg", seg, 8'hF1);
    chk("t4_rej_none", coin_reject, 0);
    coin();
    chk("t4_rej", coin_reject, 1);
    chk("t4_credit_sat", credit, 15);
    step();
    chk("t4_rej_clear", coin_reject, 0);
    F = 1;
    step();
    F = 0;
    C = 1;
    step();
    C = 0;
    chk("t4_rej_refund", coin_reject, 1);
    chk("t4_credit14", credit, 14);
    begin
      int n = 0;
      while (state != 0 && n < 40) begin
        step();
        n++;
      end
      chk("t4_refund_done", n < 40, 1);
    end
    chk("t4_credit_end", credit, 0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      coin();
      sel(2'b01);
      chk("t5_vend", o, 2'b01);
      step();
    end
    chk("t5_stock_empty", dut.stock_q[0], 0);
    coin();
    chk("t5_led_empty", led, 2'b00);
    sel(2'b01);
    chk("t5_o_ignored", o, 0);
    chk("t5_credit_kept", credit, 1);
    refill = 1;
    C = 1;
    step();
    refill = 0;
    C = 0;
    chk("t5_led_refill", led, 2'b01);
    chk("t5_rej_dropped", coin_reject, 1);
    chk("t5_credit_nochg", credit, 1);
    do_reset();
    repeat (3) coin();
    chk("t6_credit3", credit_a, 3);
    sel(2'b10);
    chk("t6_o", o_a, 2'b10);
    chk("t6_credit1", credit_a, 1);
    chk("t6_state_vend", state_a, 2'b01);
    step();
    chk("t6_state_ref", state_a, 2'b10);
    chk("t6_o_clear", o_a, 0);
    step();
    chk("t6_chg", change_a, 1);
    chk("t6_credit0", credit_a, 0);
    chk("t6_state_idle", state_a, 0);
    chk("t6_ref_no_auto", state, 0);
    step();
    chk("t6_chg_end", change_a, 0);
    repeat (3) coin();
    F = 1;
    step();
    F = 0;
    step();
    chk("t6_mid_credit", credit_a, 2);
    do_reset();
    chk("t6_rst_credit", credit_a, 0);
    chk("t6_rst_state", state_a, 0);
    chk("t6_rst_chg", change_a, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
